dht11_temp_reader: RTL and testbench

//  Upstream stage of the fan-control FSM. Periodically queries a DHT11 sensor over its single-wire bus.

---
 rtl/dht_pkg.sv | 26 ++
 rtl/dht_us_tick.sv | 32 +++
 rtl/dht11_temp_reader.sv | 183 ++++++++++++++++++
 tb/tb_dht11_temp_reader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11 reader: FSM encoding, frame geometry and
// the checksum rule for a received 40-bit frame.
package dht_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_LOW = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_RESP_LOW  = 3'd3,
        ST_RESP_HIGH = 3'd4,
        ST_BIT_LOW   = 3'd5,
        ST_BIT_HIGH  = 3'd6,
        ST_CHECK     = 3'd7
    } dht_state_e;

    localparam int FRAME_BITS = 40;
    localparam int US_PER_MS  = 1000;

    // Frame layout is {hum_i, hum_d, tmp_i, tmp_d, chk}; chk is the byte sum mod 256.
    function automatic logic frame_chk_ok(input logic [FRAME_BITS-1:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return (sum == frame[7:0]);
    endfunction

endpackage

// File: rtl/dht_us_tick.sv
// Free-running prescaler: one-cycle strobe every microsecond of system clock.
module dht_us_tick #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With a 1 MHz clock the counter never leaves zero and the strobe is constant.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/dht11_temp_reader.sv
// DHT11 single-wire reader: periodic start pulse, response/bit decode, checksum,
// and last-good integer temperature/humidity with valid/err strobes.
module dht11_temp_reader
    import dht_pkg::*;
#(
    parameter int CLK_HZ           = 50_000_000,
    parameter int SAMPLE_PERIOD_MS = 2000,
    parameter int START_LOW_MS     = 18,
    parameter int TIMEOUT_US       = 200,
    parameter int BIT1_MIN_US      = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic [7:0] temp,
    output logic [7:0] hum,
    output logic       valid,
    output logic       err,
    output logic       busy
);

    localparam logic [14:0] US_LAST     = 15'(US_PER_MS - 1);
    localparam logic [11:0] PERIOD_LAST = 12'(SAMPLE_PERIOD_MS - 1);
    localparam logic [11:0] START_LAST  = 12'(START_LOW_MS - 1);
    localparam logic [14:0] TIMEOUT     = 15'(TIMEOUT_US);
    localparam logic [14:0] BIT1_MIN    = 15'(BIT1_MIN_US);
    localparam logic [5:0]  LAST_BIT    = 6'(FRAME_BITS - 1);

    logic tick;

    dht_us_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Bus idles high (external pull-up), so the synchronizer resets to 1.
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= dht_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    logic bus_fall, bus_rise;
    assign bus_fall = prev_q & ~sync2_q;
    assign bus_rise = ~prev_q & sync2_q;

    dht_state_e            state_q, state_d;
    logic [14:0]           us_q, us_d;
    logic [11:0]           ms_q, ms_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [7:0]            temp_q, temp_d;
    logic [7:0]            hum_q, hum_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic [14:0] us_next;
    logic        ms_wrap;
    logic        in_sensor_phase;

    assign us_next         = us_q + {14'd0, tick};
    assign ms_wrap         = tick && (us_q == US_LAST);
    assign in_sensor_phase = (state_q inside {ST_WAIT_RESP, ST_RESP_LOW, ST_RESP_HIGH,
                                              ST_BIT_LOW, ST_BIT_HIGH});

    always_comb begin
        state_d   = state_q;
        us_d      = us_next;
        ms_d      = ms_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        temp_d    = temp_q;
        hum_d     = hum_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        // Millisecond phases fold the us timer into the ms counter.
        if ((state_q == ST_IDLE || state_q == ST_START_LOW) && ms_wrap) begin
            us_d = '0;
            ms_d = ms_q + 12'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (ms_wrap && ms_q == PERIOD_LAST) state_d = ST_START_LOW;
            end
            ST_START_LOW: begin
                if (ms_wrap && ms_q == START_LAST) state_d = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (bus_fall) state_d = ST_RESP_LOW;
            end
            ST_RESP_LOW: begin
                if (bus_rise) state_d = ST_RESP_HIGH;
            end
            ST_RESP_HIGH: begin
                if (bus_fall) begin
                    state_d   = ST_BIT_LOW;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            ST_BIT_LOW: begin
                if (bus_rise) state_d = ST_BIT_HIGH;
            end
            ST_BIT_HIGH: begin
                if (bus_fall) begin
                    // us_next includes the edge cycle, so a high of N us measures N.
                    shift_d   = {shift_q[FRAME_BITS-2:0], (us_next >= BIT1_MIN)};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (frame_chk_ok(shift_q)) begin
                    hum_d   = shift_q[39:32];
                    temp_d  = shift_q[23:16];
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (in_sensor_phase && us_q == TIMEOUT) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end

        // Every phase, including the idle wait, times from its own entry.
        if (state_d != state_q) begin
            us_d = '0;
            ms_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            us_q      <= '0;
            ms_q      <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            temp_q    <= '0;
            hum_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            us_q      <= us_d;
            ms_q      <= ms_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            temp_q    <= temp_d;
            hum_q     <= hum_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Bus drive decodes straight from state so reset releases it with no clock.
    assign dht_oe = (state_q == ST_START_LOW);
    assign busy   = (state_q != ST_IDLE);
    assign temp   = temp_q;
    assign hum    = hum_q;
    assign valid  = valid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dht11_temp_reader.sv
// Directed bench for dht11_temp_reader with a behavioural open-drain DHT11 model;
// 1 MHz clock so one cycle equals one microsecond.
module tb_dht11_temp_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sensor_drive = 1'b1;
    logic       dht_in;
    logic       dht_oe;
    logic [7:0] temp;
    logic [7:0] hum;
    logic       valid;
    logic       err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    int         valid_cnt = 0;
    int         err_cnt   = 0;
    int         both_cnt  = 0;
    logic [7:0] v_temp    = 8'd0;
    logic [7:0] v_hum     = 8'd0;

    localparam logic [39:0] FRAME_GOOD = 40'h37_00_1A_00_51;
    localparam logic [39:0] FRAME_BAD  = 40'h37_00_1A_00_52;

    // High widths for the first nibble of FRAME_GOOD (bits 0,0,1,1).
    int bw_tab[4] = '{27, 39, 40, 70};

    assign dht_in = dht_oe ? 1'b0 : sensor_drive;

    dht11_temp_reader #(
        .CLK_HZ           (1_000_000),
        .SAMPLE_PERIOD_MS (5),
        .START_LOW_MS     (18),
        .TIMEOUT_US       (200),
        .BIT1_MIN_US      (40)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .dht_in (dht_in),
        .dht_oe (dht_oe),
        .temp   (temp),
        .hum    (hum),
        .valid  (valid),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard of output strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                valid_cnt++;
                v_temp = temp;
                v_hum  = hum;
            end
            if (err) err_cnt++;
            if (valid && err) both_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic level, input int n);
        sensor_drive = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_oe(input logic level, input int limit, output int cyc);
        cyc = 0;
        while (dht_oe !== level && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (dht_oe !== level) check_val("oe_wait_timeout", {31'd0, dht_oe}, {31'd0, level});
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy === 1'b1 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (busy !== 1'b0) check_val("idle_wait_timeout", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // Sensor answer; stops early (line low mid-bit) when stop_bit < 40.
    task automatic sensor_frame(input logic [39:0] frame, input int stop_bit, input bit use_bw);
        int hi;
        drive(1'b1, 30);
        drive(1'b0, 80);
        drive(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            if (i == stop_bit) begin
                drive(1'b0, 25);
                return;
            end
            drive(1'b0, 50);
            hi = frame[39-i] ? 70 : 27;
            if (use_bw && i < 4) hi = bw_tab[i];
            drive(1'b1, hi);
        end
        drive(1'b0, 50);
        sensor_drive = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;

        // Reset state
        repeat (5) @(negedge clk);
        check_val("rst_dht_oe", {31'd0, dht_oe}, 32'd0);
        check_val("rst_temp", {24'd0, temp}, 32'd0);
        check_val("rst_hum", {24'd0, hum}, 32'd0);
        check_val("rst_valid", {31'd0, valid}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // First read: 5 ms idle, 18 ms start pulse
        wait_oe(1'b1, 10000, cyc);
        check_val("first_idle_cycles", cyc, 32'd5000);
        check_val("busy_in_start", {31'd0, busy}, 32'd1);
        wait_oe(1'b0, 30000, cyc);
        check_val("start_low_cycles", cyc, 32'd18000);

        // Good frame with 27/39/40/70 us highs on the first nibble
        sensor_frame(FRAME_GOOD, 40, 1'b1);
        wait_idle();
        check_val("good_valid_cnt", valid_cnt, 32'd1);
        check_val("good_err_cnt", err_cnt, 32'd0);
        check_val("good_temp", {24'd0, temp}, 32'd26);
        check_val("good_hum", {24'd0, hum}, 32'd55);
        check_val("valid_strobe_temp", {24'd0, v_temp}, 32'd26);
        check_val("valid_strobe_hum", {24'd0, v_hum}, 32'd55);

        // Bad checksum
        wait_oe(1'b1, 10000, cyc);
        wait_oe(1'b0, 30000, cyc);
        sensor_frame(FRAME_BAD, 40, 1'b0);
        wait_idle();
        check_val("badchk_err_cnt", err_cnt, 32'd1);
        check_val("badchk_valid_cnt", valid_cnt, 32'd1);
        check_val("badchk_temp_held", {24'd0, temp}, 32'd26);
        check_val("badchk_hum_held", {24'd0, hum}, 32'd55);

        // No response: timer hits 200 us, err registered one cycle later
        wait_oe(1'b1, 10000, cyc);
        wait_oe(1'b0, 30000, cyc);
        cyc = 0;
        while (err !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check_val("timeout_err_delay", cyc, 32'd201);
        check_val("timeout_busy_low", {31'd0, busy}, 32'd0);
        wait_oe(1'b1, 10000, cyc);
        check_val("retry_idle_cycles", cyc, 32'd5000);
        check_val("timeout_err_cnt", err_cnt, 32'd2);
        check_val("timeout_temp_held", {24'd0, temp}, 32'd26);

        // Reset in the middle of bit 20
        wait_oe(1'b0, 30000, cyc);
        sensor_frame(FRAME_GOOD, 20, 1'b0);
        check_val("midframe_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("midrst_dht_oe", {31'd0, dht_oe}, 32'd0);
        check_val("midrst_temp", {24'd0, temp}, 32'd0);
        check_val("midrst_hum", {24'd0, hum}, 32'd0);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        sensor_drive = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_oe(1'b1, 10000, cyc);
        check_val("post_rst_idle_cycles", cyc, 32'd5000);
        check_val("final_valid_cnt", valid_cnt, 32'd1);
        check_val("final_err_cnt", err_cnt, 32'd2);
        check_val("valid_err_overlap", both_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
